fifo_wr_ctrl: RTL

//  Write-side controller for the pointer-based FIFO; sits upstream of the read-pointer stage and supplies its w_ptr.

---
 rtl/fifo_pkg.sv | 31 +++
 rtl/fifo_wr_ctrl_if.sv | 21 ++
 rtl/fifo_ptr_cmp.sv | 19 +
 rtl/fifo_wr_ctrl.sv | 124 ++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO types and pointer helpers.
// Used by both the write-side and read-side pointer stages.
package fifo_pkg;

    typedef enum logic {
        PASS = 1'b0,
        HOLD = 1'b1
    } wr_state_t;

    // Pointers are passed zero-extended to 32 bits; pw is the real width.
    function automatic logic ptr_full(
        input logic [31:0] w,
        input logic [31:0] r,
        input int          pw
    );
        logic [31:0] m;
        m = (32'd1 << (pw - 1)) - 32'd1;
        return ((w & m) == (r & m)) && (w[pw-1] != r[pw-1]);
    endfunction

    function automatic logic [31:0] ptr_count(
        input logic [31:0] w,
        input logic [31:0] r,
        input int          pw
    );
        logic [31:0] m;
        m = (32'd1 << pw) - 32'd1;
        return (w - r) & m;
    endfunction

endpackage

// File: rtl/fifo_wr_ctrl_if.sv
// Upstream valid/ready message stream into the FIFO write side.
// master = producer, slave = fifo_wr_ctrl.
interface fifo_wr_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  in_val;
    logic                  in_rdy;
    logic [DATA_WIDTH-1:0] in_msg;

    modport master (
        output in_val,
        output in_msg,
        input  in_rdy
    );

    modport slave (
        input  in_val,
        input  in_msg,
        output in_rdy
    );
endinterface

// File: rtl/fifo_ptr_cmp.sv
// Combinational full/empty/occupancy from two extended pointers.
// Wrap bit is the pointer MSB.
module fifo_ptr_cmp
    import fifo_pkg::*;
#(
    parameter int PTR_WIDTH = 3
) (
    input  logic [PTR_WIDTH-1:0] w_ptr,
    input  logic [PTR_WIDTH-1:0] r_ptr,
    output logic                 full,
    output logic                 empty,
    output logic [PTR_WIDTH-1:0] count
);

    assign full  = ptr_full(32'(w_ptr), 32'(r_ptr), PTR_WIDTH);
    assign empty = (w_ptr == r_ptr);
    assign count = PTR_WIDTH'(ptr_count(32'(w_ptr), 32'(r_ptr), PTR_WIDTH));

endmodule

// File: rtl/fifo_wr_ctrl.sv
// FIFO write-side controller with one-entry skid so in_rdy is registered.
// Optional hold-cycle statistics enabled by FIFO_WR_STATS_EN.
module fifo_wr_ctrl
    import fifo_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int PTR_WIDTH    = $clog2(DEPTH) + 1,
    parameter int DATA_WIDTH   = 8,
    parameter int AFULL_THRESH = DEPTH - 1
) (
    input  logic                  clk,
    input  logic                  rst,
    fifo_wr_ctrl_if.slave         up,
    input  logic [PTR_WIDTH-1:0]  r_ptr,
    output logic [PTR_WIDTH-1:0]  w_ptr,
    output logic                  wen,
    output logic [PTR_WIDTH-2:0]  waddr,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  full,
    output logic                  almost_full,
    output logic [PTR_WIDTH-1:0]  count,
    output logic [15:0]           stall_cnt
);

    localparam logic [PTR_WIDTH-1:0] AF_LVL = PTR_WIDTH'(AFULL_THRESH);

    wr_state_t             state_q;
    wr_state_t             state_d;
    logic [DATA_WIDTH-1:0] skid_q;
    logic                  skid_ld;
    logic [PTR_WIDTH-1:0]  w_ptr_q;
    logic                  empty;

    fifo_ptr_cmp #(
        .PTR_WIDTH (PTR_WIDTH)
    ) u_cmp (
        .w_ptr (w_ptr_q),
        .r_ptr (r_ptr),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign almost_full = (count >= AF_LVL);
    assign w_ptr       = w_ptr_q;
    assign waddr       = w_ptr_q[PTR_WIDTH-2:0];
    assign up.in_rdy   = (state_q == PASS);

    // Next state, write strobe and skid capture; reset suppresses writes.
    always_comb begin
        state_d = state_q;
        wen     = 1'b0;
        wdata   = up.in_msg;
        skid_ld = 1'b0;
        unique case (state_q)
            PASS: begin
                if (up.in_val && !full) begin
                    wen = 1'b1;
                end else if (up.in_val) begin
                    skid_ld = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                wdata = skid_q;
                if (!full) begin
                    wen     = 1'b1;
                    state_d = PASS;
                end
            end
            default: state_d = PASS;
        endcase
        if (rst) begin
            wen     = 1'b0;
            skid_ld = 1'b0;
        end
    end

    // State and write pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PASS;
            w_ptr_q <= '0;
        end else begin
            state_q <= state_d;
            if (wen) begin
                w_ptr_q <= w_ptr_q + 1'b1;
            end
        end
    end

    // Skid register holds the message accepted while full; no reset needed.
    always_ff @(posedge clk) begin
        if (skid_ld) begin
            skid_q <= up.in_msg;
        end
    end

`ifdef FIFO_WR_STATS_EN
    logic [15:0] stall_q;

    // Saturating count of cycles spent holding a skid message.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if (state_q == HOLD && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

    a_no_wen_full : assert property (
        @(posedge clk) disable iff (rst) !(wen && full)
    );

    a_empty_cnt : assert property (
        @(posedge clk) disable iff (rst) empty |-> (count == '0)
    );

endmodule
